// File: rtl/data_mem_ctrl_if.sv
// Bus bundle between the core, the data memory controller and its SRAM.
interface data_mem_ctrl_if #(
    parameter int AW = 10
);
    logic          ce_i;
    logic          we_i;
    logic [31:0]   addr_i;
    logic [31:0]   wdata_i;
    logic [31:0]   rdata_o;
    logic          rvalid_o;
    logic          misalign_o;
    logic          stall_o;
    logic          sb_empty_o;
    logic          sram_en_o;
    logic          sram_we_o;
    logic [AW-1:0] sram_addr_o;
    logic [31:0]   sram_wdata_o;
    logic [31:0]   sram_rdata_i;

    // Controller side: takes core requests and SRAM read data
    modport slave (
        input  ce_i, we_i, addr_i, wdata_i, sram_rdata_i,
        output rdata_o, rvalid_o, misalign_o, stall_o, sb_empty_o,
        output sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o
    );

    // Core/SRAM side: issues requests and returns SRAM read data
    modport master (
        output ce_i, we_i, addr_i, wdata_i, sram_rdata_i,
        input  rdata_o, rvalid_o, misalign_o, stall_o, sb_empty_o,
        input  sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory controller: store buffer with load forwarding in front of a
// single-port synchronous SRAM. Loads that miss the buffer take a two-cycle
// SRAM read; buffered stores drain whenever the SRAM port is otherwise free.
module data_mem_ctrl #(
    parameter int DEPTH    = 1024,
    parameter int SB_DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    data_mem_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  sb_idx_q  [SB_DEPTH];
    logic [31:0]    sb_data_q [SB_DEPTH];
    logic [31:0]    rdata_q, rdata_d;
    logic           rvalid_q, rvalid_d;
    logic           misalign_q, misalign_d;

    logic           aligned;
    logic [AW-1:0]  req_idx;
    logic           hit;
    logic [31:0]    hit_data;
    logic           stall;
    logic           miss_issue;
    logic           accept;
    logic           push;
    logic           drain;
    logic           load_accept;
    logic           unused_addr_bits;

    assign aligned          = (bus.addr_i[1:0] == 2'b00);
    assign req_idx          = bus.addr_i[AW+1:2];
    assign unused_addr_bits = ^bus.addr_i[31:AW+2];

    // Search valid entries oldest to youngest so the youngest match wins
    always_comb begin : sb_search
        logic [PW-1:0] pos;
        hit      = 1'b0;
        hit_data = 32'h0;
        pos      = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            pos = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (sb_idx_q[pos] == req_idx)) begin
                hit      = 1'b1;
                hit_data = sb_data_q[pos];
            end
        end
    end

    // Request acceptance, SRAM port arbitration (miss read beats drain) and next state
    always_comb begin
        stall      = 1'b0;
        miss_issue = 1'b0;
        if (!rst && bus.ce_i && aligned) begin
            if (bus.we_i) begin
                stall = (count_q == CW'(SB_DEPTH));
            end else if (state_q == IDLE && !hit) begin
                stall      = 1'b1;
                miss_issue = 1'b1;
            end
        end

        accept      = !rst && bus.ce_i && !stall;
        push        = accept && bus.we_i && aligned;
        load_accept = accept && !bus.we_i;
        drain       = !rst && !miss_issue && (count_q != '0);

        state_d  = miss_issue ? RD_WAIT : IDLE;
        count_d  = count_q + CW'(push) - CW'(drain);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(drain);

        rdata_d    = rdata_q;
        rvalid_d   = load_accept;
        misalign_d = accept && !aligned;
        if (load_accept) begin
            if (!aligned) begin
                rdata_d = 32'h0;
            end else if (state_q == RD_WAIT) begin
                rdata_d = bus.sram_rdata_i;
            end else begin
                rdata_d = hit_data;
            end
        end
    end

    // Control state, buffer bookkeeping and registered load return
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rdata_q    <= 32'h0;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            misalign_q <= misalign_d;
        end
    end

    // Buffer payload needs no reset: entries are only meaningful below count
    always_ff @(posedge clk) begin
        if (push) begin
            sb_idx_q[wr_ptr_q]  <= req_idx;
            sb_data_q[wr_ptr_q] <= bus.wdata_i;
        end
    end

    assign bus.stall_o      = stall;
    assign bus.rdata_o      = rdata_q;
    assign bus.rvalid_o     = rvalid_q;
    assign bus.misalign_o   = misalign_q;
    assign bus.sb_empty_o   = (count_q == '0);
    assign bus.sram_en_o    = miss_issue || drain;
    assign bus.sram_we_o    = drain;
    assign bus.sram_addr_o  = miss_issue ? req_idx : sb_idx_q[rd_ptr_q];
    assign bus.sram_wdata_o = sb_data_q[rd_ptr_q];
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed scenarios plus random traffic, all
// compared cycle by cycle against a queue-based memory model.
module tb_data_mem_ctrl;
    localparam int DEPTH    = 1024;
    localparam int SB_DEPTH = 4;
    localparam int AW       = 10;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [31:0]   data;
    } sb_ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_mem_ctrl_if #(.AW(AW)) bus ();

    data_mem_ctrl #(.DEPTH(DEPTH), .SB_DEPTH(SB_DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Synchronous SRAM: write on enable+we, read data valid the next cycle
    logic [31:0] sram_mem [DEPTH];
    always @(posedge clk) begin
        if (bus.sram_en_o) begin
            if (bus.sram_we_o) sram_mem[bus.sram_addr_o] <= bus.sram_wdata_o;
            else               bus.sram_rdata_i <= sram_mem[bus.sram_addr_o];
        end
    end

    // Count SRAM writes that happen while reset is held
    int writes_in_rst = 0;
    always @(posedge clk) begin
        if (rst && bus.sram_en_o && bus.sram_we_o) writes_in_rst++;
    end

    // Model: pending stores in order, committed memory, outstanding miss, last load data
    sb_ent_t     mq[$];
    logic [31:0] committed [DEPTH];
    bit          m_waiting = 1'b0;
    logic [31:0] m_rdata   = 32'h0;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    bit last_dut_stall;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive a request, check combinational outputs, clock, check registered outputs
    task automatic applyStimulus(input logic ce, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, output bit accepted);
        bit            aligned, hit, exp_stall, miss, drain;
        logic [AW-1:0] idx;
        logic [31:0]   fwd, exp_load;
        sb_ent_t       e;
        bus.ce_i    = ce;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.wdata_i = wdata;
        #1;
        aligned = (addr[1:0] == 2'b00);
        idx     = addr[AW+1:2];
        hit     = 1'b0;
        fwd     = 32'h0;
        foreach (mq[i]) begin
            if (mq[i].idx == idx) begin
                hit = 1'b1;
                fwd = mq[i].data;
            end
        end
        exp_stall = 1'b0;
        miss      = 1'b0;
        if (ce && aligned && we && mq.size() == SB_DEPTH) exp_stall = 1'b1;
        if (ce && aligned && !we && !m_waiting && !hit) begin
            exp_stall = 1'b1;
            miss      = 1'b1;
        end
        drain    = !miss && (mq.size() > 0);
        exp_load = hit ? fwd : committed[idx];

        last_dut_stall = bus.stall_o;
        checkOutput("stall", {31'b0, bus.stall_o}, {31'b0, exp_stall});
        checkOutput("sram_en", {31'b0, bus.sram_en_o}, {31'b0, miss || drain});
        checkOutput("sram_we", {31'b0, bus.sram_we_o}, {31'b0, drain});
        if (miss) checkOutput("rd_addr", {22'b0, bus.sram_addr_o}, {22'b0, idx});
        if (drain) begin
            checkOutput("wr_addr", {22'b0, bus.sram_addr_o}, {22'b0, mq[0].idx});
            checkOutput("wr_data", bus.sram_wdata_o, mq[0].data);
        end
        accepted = ce && !exp_stall;

        @(posedge clk);
        if (drain) begin
            committed[mq[0].idx] = mq[0].data;
            void'(mq.pop_front());
        end
        if (accepted && we && aligned) begin
            e.idx  = idx;
            e.data = wdata;
            mq.push_back(e);
        end
        m_waiting = miss;
        if (accepted && !we) m_rdata = aligned ? exp_load : 32'h0;
        #1;
        checkOutput("rvalid", {31'b0, bus.rvalid_o}, {31'b0, accepted && !we});
        checkOutput("misalign", {31'b0, bus.misalign_o}, {31'b0, accepted && !aligned});
        checkOutput("rdata", bus.rdata_o, m_rdata);
        checkOutput("sb_empty", {31'b0, bus.sb_empty_o}, {31'b0, mq.size() == 0});
    endtask

    // Present a request until accepted (bounded), counting DUT stall cycles
    task automatic request(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output int dut_stalls);
        bit acc;
        acc        = 1'b0;
        dut_stalls = 0;
        for (int k = 0; k < 8 && !acc; k++) begin
            applyStimulus(1'b1, we, addr, wdata, acc);
            if (last_dut_stall) dut_stalls++;
        end
        checkOutput("accept_bound", {31'b0, acc}, 32'h1);
    endtask

    task automatic idleCycles(input int n);
        bit acc;
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, acc);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit          acc, r_ce, r_we, have_pend;
        logic [31:0] r_addr, r_data, v;
        int          stalls;
        logic [31:0] vals [5];

        for (int i = 0; i < DEPTH; i++) begin
            v            = $urandom;
            sram_mem[i]  = v;
            committed[i] = v;
        end
        sram_mem[16]  = 32'h1234_5678;
        committed[16] = 32'h1234_5678;
        bus.ce_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = 32'h0; bus.wdata_i = 32'h0;
        bus.sram_rdata_i = 32'h0;

        // Reset holds everything quiet even with a load presented
        #2 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        bus.ce_i = 1'b1; bus.addr_i = 32'h80;
        #1;
        checkOutput("rst_stall", {31'b0, bus.stall_o}, 32'h0);
        checkOutput("rst_sram_en", {31'b0, bus.sram_en_o}, 32'h0);
        checkOutput("rst_sram_we", {31'b0, bus.sram_we_o}, 32'h0);
        checkOutput("rst_rvalid", {31'b0, bus.rvalid_o}, 32'h0);
        checkOutput("rst_rdata", bus.rdata_o, 32'h0);
        checkOutput("rst_misalign", {31'b0, bus.misalign_o}, 32'h0);
        checkOutput("rst_sb_empty", {31'b0, bus.sb_empty_o}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0; bus.ce_i = 1'b0;

        $display("[TB] store then load forwarding");
        applyStimulus(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, acc);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, acc);
        checkOutput("fwd_accept", {31'b0, acc}, 32'h1);
        checkOutput("fwd_rdata", bus.rdata_o, 32'hDEAD_BEEF);

        $display("[TB] youngest match");
        applyStimulus(1'b1, 1'b1, 32'h20, 32'h1, acc);
        applyStimulus(1'b1, 1'b1, 32'h20, 32'h2, acc);
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, acc);
        checkOutput("young_rdata", bus.rdata_o, 32'h2);

        $display("[TB] load miss from SRAM");
        idleCycles(3);
        request(1'b0, 32'h40, 32'h0, stalls);
        checkOutput("miss_stalls", stalls, 32'h1);
        checkOutput("miss_rdata", bus.rdata_o, 32'h1234_5678);

        $display("[TB] misaligned load");
        idleCycles(2);
        applyStimulus(1'b1, 1'b0, 32'h41, 32'h0, acc);
        checkOutput("mis_flag", {31'b0, bus.misalign_o}, 32'h1);
        checkOutput("mis_rdata", bus.rdata_o, 32'h0);

        $display("[TB] stores interleaved with load misses, then read back");
        for (int i = 0; i < 5; i++) begin
            vals[i] = $urandom;
            request(1'b1, 32'h100 + 32'(i * 4), vals[i], stalls);
            request(1'b0, 32'h800 + 32'(i * 4), 32'h0, stalls);
        end
        idleCycles(SB_DEPTH + 2);
        for (int i = 0; i < 5; i++) begin
            request(1'b0, 32'h100 + 32'(i * 4), 32'h0, stalls);
            checkOutput("readback", bus.rdata_o, vals[i]);
        end

        $display("[TB] random traffic");
        have_pend = 1'b0;
        r_ce = 1'b0; r_we = 1'b0; r_addr = 32'h0; r_data = 32'h0;
        for (int n = 0; n < 400; n++) begin
            if (!have_pend) begin
                r_ce   = ($urandom_range(0, 9) < 8);
                r_we   = $urandom_range(0, 1) == 1;
                r_addr = {$urandom_range(0, 3) == 0 ? 20'($urandom) : 20'h0,
                          6'h0, 4'($urandom_range(0, 15)), 2'b00};
                if ($urandom_range(0, 9) == 0) r_addr[1:0] = 2'($urandom_range(1, 3));
                r_data = $urandom;
            end
            applyStimulus(r_ce, r_we, r_addr, r_data, acc);
            have_pend = r_ce && !acc;
        end
        idleCycles(SB_DEPTH + 2);

        $display("[TB] reset during read wait with a buffered store");
        applyStimulus(1'b1, 1'b1, 32'h200, 32'hCAFE_F00D, acc);
        applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, acc);
        rst = 1'b1;
        #1;
        checkOutput("rw_rst_rvalid", {31'b0, bus.rvalid_o}, 32'h0);
        checkOutput("rw_rst_rdata", bus.rdata_o, 32'h0);
        checkOutput("rw_rst_misalign", {31'b0, bus.misalign_o}, 32'h0);
        checkOutput("rw_rst_sb_empty", {31'b0, bus.sb_empty_o}, 32'h1);
        checkOutput("rw_rst_sram_en", {31'b0, bus.sram_en_o}, 32'h0);
        checkOutput("rw_rst_stall", {31'b0, bus.stall_o}, 32'h0);
        mq.delete();
        m_waiting = 1'b0;
        m_rdata   = 32'h0;
        @(posedge clk); @(posedge clk); #1;
        checkOutput("rw_rst_writes", writes_in_rst, 32'h0);
        rst = 1'b0; bus.ce_i = 1'b0;
        request(1'b0, 32'h200, 32'h0, stalls);
        checkOutput("discarded_store", bus.rdata_o, committed[128]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
